// File: rtl/matmul_scheduler.sv
// Two-requester scheduler for a shared 2x2x2 multiply/accumulate datapath.
// Define MATMUL_SCHED_RR_EN for round-robin arbitration; fixed priority (req[0] first) otherwise.
module matmul_scheduler (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       busy,
    output logic       mult_en,
    output logic       acc_clr,
    output logic       acc_en,
    output logic [2:0] idx,
    output logic       wr_en,
    output logic [1:0] wr_addr,
    output logic [1:0] done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q;
    logic [2:0] cnt_q;
    logic       owner_q;
    logic       win_d;
    logic       owner_req;
    logic [1:0] owner_oh;

`ifdef MATMUL_SCHED_RR_EN
    logic last_q;

    // On contention the requester that was not served last wins.
    always_comb begin
        win_d = req[1];
        if (req == 2'b11) win_d = ~last_q;
    end
`else
    always_comb begin
        win_d = ~req[0];
    end
`endif

    assign owner_req = req[owner_q];
    assign owner_oh  = owner_q ? 2'b10 : 2'b01;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            owner_q <= 1'b0;
`ifdef MATMUL_SCHED_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= 3'd0;
                    if (req != 2'b00) begin
                        owner_q <= win_d;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    // Owner withdrawing its request aborts the job outright.
                    if (!owner_req) begin
                        state_q <= IDLE;
                        cnt_q   <= 3'd0;
                    end else if (cnt_q == 3'd7) begin
                        state_q <= STORE;
                        cnt_q   <= 3'd0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                STORE: begin
                    state_q <= owner_req ? DONE : IDLE;
                end
                DONE: begin
                    state_q <= IDLE;
`ifdef MATMUL_SCHED_RR_EN
                    last_q  <= owner_q;
`endif
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end

    // Products pair up as (k=0, k=1): even idx clears-and-loads, odd idx adds,
    // so each result element is ready to store one cycle after its odd product.
    always_comb begin
        grant   = 2'b00;
        busy    = 1'b0;
        mult_en = 1'b0;
        acc_en  = 1'b0;
        acc_clr = 1'b0;
        idx     = 3'd0;
        wr_en   = 1'b0;
        wr_addr = 2'b00;
        done    = 2'b00;
        case (state_q)
            MAC: begin
                grant   = owner_oh;
                busy    = 1'b1;
                mult_en = 1'b1;
                acc_en  = 1'b1;
                acc_clr = ~cnt_q[0];
                idx     = cnt_q;
                if (!cnt_q[0] && cnt_q != 3'd0) begin
                    wr_en   = 1'b1;
                    wr_addr = cnt_q[2:1] - 2'd1;
                end
            end
            STORE: begin
                grant   = owner_oh;
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = 2'd3;
            end
            DONE: begin
                grant = owner_oh;
                busy  = 1'b1;
                done  = owner_oh;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matmul_scheduler.sv
// Self-checking bench for matmul_scheduler: directed job scenarios plus random
// request traffic, all checked every cycle against a job-age reference model.
module tb_matmul_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req   = 2'b00;
    logic [1:0] grant;
    logic       busy;
    logic       mult_en;
    logic       acc_clr;
    logic       acc_en;
    logic [2:0] idx;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [1:0] done;
    logic [13:0] outs;

    int tests = 0;
    int fails = 0;

    matmul_scheduler dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .grant   (grant),
        .busy    (busy),
        .mult_en (mult_en),
        .acc_clr (acc_clr),
        .acc_en  (acc_en),
        .idx     (idx),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .done    (done)
    );

    assign outs = {grant, busy, mult_en, acc_en, acc_clr, idx, wr_en, wr_addr, done};

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a job is described only by its owner and its age in
    // cycles since the grant (age 0 = idle, 1..8 MAC, 9 store, 10 done).
    int m_age  = 0;
    int m_own  = 0;
    int m_last = 1;

    function automatic int pick(input logic [1:0] r, input int last);
`ifdef MATMUL_SCHED_RR_EN
        if (r == 2'b11) return 1 - last;
        return r[1] ? 1 : 0;
`else
        return r[0] ? 0 : 1;
`endif
    endfunction

    initial begin
        logic [1:0] e_oh;
        bit         mac;
        bit         e_wr;
        @(posedge clock);
        forever begin
            @(negedge clock);
            e_oh = (m_own == 1) ? 2'b10 : 2'b01;
            mac  = (m_age >= 1 && m_age <= 8);
            e_wr = (m_age == 3 || m_age == 5 || m_age == 7 || m_age == 9);
            chk("grant",   grant,   (m_age > 0) ? e_oh : 2'b00);
            chk("busy",    busy,    m_age > 0);
            chk("mult_en", mult_en, mac);
            chk("acc_en",  acc_en,  mac);
            chk("acc_clr", acc_clr, mac && ((m_age - 1) % 2 == 0));
            chk("idx",     idx,     mac ? m_age - 1 : 0);
            chk("wr_en",   wr_en,   e_wr);
            chk("wr_addr", wr_addr, e_wr ? (m_age - 3) / 2 : 0);
            chk("done",    done,    (m_age == 10) ? e_oh : 2'b00);
            // Inputs are stable here and are exactly what the next edge samples.
            if (reset) begin
                m_age  = 0;
                m_last = 1;
            end else if (m_age == 0) begin
                if (req != 2'b00) begin
                    m_own = pick(req, m_last);
                    m_age = 1;
                end
            end else if (m_age == 10) begin
                m_last = m_own;
                m_age  = 0;
            end else if (!req[m_own]) begin
                m_age = 0;
            end else begin
                m_age++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves the DUT in IDLE; the caller's next req value is sampled at cycle 0.
    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_g [3];
        logic [1:0] nreq;
`ifdef MATMUL_SCHED_RR_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01;
`endif
        tick();
        tick();
        chk("reset_outs", outs, 14'd0);

        // Single job for requester 0: full cycle-by-cycle timeline.
        do_reset();
        req = 2'b01;
        for (int n = 1; n <= 12; n++) begin
            tick();
            chk("s1_grant", grant, (n <= 10) ? 2'b01 : 2'b00);
            chk("s1_busy",  busy,  n <= 10);
            chk("s1_idx",   idx,   (n <= 8) ? n - 1 : 0);
            chk("s1_clr",   acc_clr, (n <= 8) && (n % 2 == 1));
            chk("s1_wr",    wr_en, (n == 3 || n == 5 || n == 7 || n == 9));
            chk("s1_waddr", wr_addr, (n == 3) ? 0 : (n == 5) ? 1 : (n == 7) ? 2 : (n == 9) ? 3 : 0);
            chk("s1_done",  done,  (n == 10) ? 2'b01 : 2'b00);
            if (n == 10) req = 2'b00;
        end

        // Both requesters held: three back-to-back jobs, 11 cycles apart.
        do_reset();
        req = 2'b11;
        for (int n = 1; n <= 33; n++) begin
            tick();
            for (int j = 0; j < 3; j++) begin
                if (n == 1 + 11 * j)  chk("s2_grant", grant, exp_g[j]);
                if (n == 10 + 11 * j) chk("s2_done",  done,  exp_g[j]);
                if (n == 11 + 11 * j) chk("s2_gap",   grant, 2'b00);
            end
            if (n == 32) req = 2'b00;
        end

        // Owner 0 aborts at cycle 4; pending requester 1 takes over.
        do_reset();
        req = 2'b01;
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (n == 4) req = 2'b10;
            if (n == 5) chk("s3_idle", outs, 14'd0);
            if (n >= 4 && n <= 5) chk("s3_nowr", wr_en, 1'b0);
            if (n == 6) chk("s3_grant1", grant, 2'b10);
            if (n != 15) chk("s3_nodone", done, 2'b00);
            if (n == 15) begin
                chk("s3_done1", done, 2'b10);
                req = 2'b00;
            end
        end

        // Reset in the middle of MAC.
        do_reset();
        req = 2'b01;
        for (int n = 1; n <= 17; n++) begin
            tick();
            if (n == 5) reset = 1'b1;
            if (n == 6) begin
                chk("s4_rst_outs", outs, 14'd0);
                reset = 1'b0;
                req   = 2'b11;
            end
            if (n == 7) chk("s4_grant0", grant, 2'b01);
            if (n <= 15) chk("s4_nodone", done, 2'b00);
            if (n == 16) begin
                chk("s4_done0", done, 2'b01);
                req = 2'b00;
            end
        end

        // Late request from 1 is ignored until the running job completes.
        do_reset();
        req = 2'b01;
        for (int n = 1; n <= 22; n++) begin
            tick();
            if (n == 2) req = 2'b11;
            if (n <= 10) chk("s5_hold", grant, 2'b01);
            if (n == 10) req = 2'b10;
            if (n == 11) chk("s5_idle", grant, 2'b00);
            if (n == 12) chk("s5_grant1", grant, 2'b10);
            if (n == 21) begin
                chk("s5_done1", done, 2'b10);
                req = 2'b00;
            end
        end

        // Random traffic: requests, mid-job withdrawals and occasional resets.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            tick();
            nreq = req;
            for (int r = 0; r < 2; r++) begin
                if (done[r])              nreq[r] = 1'b0;
                else if (!req[r])         nreq[r] = ($urandom_range(3) == 0);
                else if ($urandom_range(59) == 0) nreq[r] = 1'b0;
            end
            req   = nreq;
            reset = ($urandom_range(149) == 0);
        end
        reset = 1'b0;
        req   = 2'b00;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
